bus_slave_bram: RTL and testbench
=================================

// Module: bus_slave_bram
// PURPOSE
// - Bus responder (slave end) of the CPU bus protocol: accepts req/grant-arbitrated
//   transactions from a bus master and serves them from an on-chip block RAM.
// - Sits behind the bus arbiter/address decoder; answers each access with a one-cycle
//   ready pulse, read data valid in that same cycle. Memory is word-addressed with byte-lane writes.
// PARAMETERS
// - ADDR_W       10   word-address width; RAM depth = 2**ADDR_W 32-bit words
// - WAIT_CYCLES  0    extra wait states inserted before ready (0..15)
// PORTS
// - clk        in   1   clock
// - rst        in   1   reset: synchronous, active-high
// - s_cs       in   1   chip select from decoder/arbiter (grant & address hit)
// - s_as       in   1   address strobe; access valid only when s_cs & s_as
// - s_addr     in   32  byte address; bits [ADDR_W+1:2] index RAM
// - s_wr_data  in   32  write data
// - s_we       in   1   1 = write, 0 = read
// - s_sel      in   4   byte enables; s_sel[i] enables byte lane i (bits 8i+7:8i)
// - s_rd_data  out  32  read data; valid only while s_ready=1, else 0
// - s_ready    out  1   transaction complete, single-cycle pulse
// BEHAVIOUR
// - Reset: state IDLE, s_ready=0, s_rd_data=0, wait counter=0, latched request cleared.
//   RAM contents are not cleared by reset.
// - FSM IDLE -> ACCESS -> READY -> RECOVER -> IDLE.
// - IDLE: on s_cs & s_as, latch s_addr/s_we/s_sel/s_wr_data, load counter with WAIT_CYCLES,
//   and go to ACCESS.
// - ACCESS while counter != 0: decrement. If s_cs drops, abort to IDLE, no write, no ready.
// - ACCESS at counter == 0: commit.
//   - Write: byte-masked write of the latched lanes; the other lanes are unchanged.
//   - Read: RAM read issued.
//   - Then go to READY.
// - READY: s_ready=1 for exactly one cycle. Read: s_rd_data = full 32-bit word; s_sel does
//   not mask read data. Write: s_rd_data = 0. Next state is RECOVER.
// - RECOVER: one dead cycle, s_cs ignored. Covers the master's req drop and the grant update
//   one cycle later; prevents a stale re-trigger. Next state is IDLE.
// - Latency, with cs sampled high at edge T: s_ready is high in cycle T+2+WAIT_CYCLES.
//   Back-to-back accesses: next accept at the earliest 2 cycles after ready.
// - s_addr[1:0] are ignored: misaligned addresses round down.
// - Address bits above ADDR_W+1 are ignored: accesses alias/wrap modulo the RAM size.
// - s_sel=4'b0000 write: completes with ready and modifies nothing.
// - Inputs changing after acceptance have no effect; only the latched copy is used.
// - Reset mid-transaction: returns to IDLE next edge. An uncommitted write is dropped and
//   no ready is issued.
// - s_ready and s_rd_data are driven from registers/RAM output, with no combinational path
//   from s_cs.
// STRUCTURE
// - bus_pkg: state enum typedef (IDLE/ACCESS/READY/RECOVER), bus width constants
//   (addr 32, data 32, sel 4), EN/DIS_EN constants shared with the master side.
// - Sub-module bram_be_sp: single-port synchronous RAM with 4 byte-write enables,
//   1-cycle read latency, parameter ADDR_W. It must map to vendor BRAM.
// - Top level holds the FSM, the wait counter, the request latch and output gating.
// TESTING
// - Write then read: write 0xDEADBEEF @0x10, sel=F, then read @0x10 -> ready at T+2,
//   rd_data=0xDEADBEEF.
// - Byte lanes: init 0x11223344 @0x20, write 0xAABBCCDD sel=4'b0101 -> read 0x11BB33DD.
// - Wait states: WAIT_CYCLES=3, read @0x4 -> s_ready exactly at T+5, one cycle wide,
//   rd_data=0 otherwise.
// - Abort and reset: drop s_cs during ACCESS, or assert rst before commit, on write 0x5 @0x30
//   -> no ready, old word intact.
// - Back-to-back and alias: hold s_cs high over two writes -> one ready per access, no double
//   commit in RECOVER; read @(0x30 + 4*2**ADDR_W) returns the word @0x30.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared CPU bus types and constants
// Purpose: FSM state type, bus widths and enable levels used by bus masters and responders.
package bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_SEL_W  = 4;

   localparam logic EN     = 1'b1;
   localparam logic DIS_EN = 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      READY   = 2'd2,
      RECOVER = 2'd3
   } bus_state_t;

endpackage

// File: rtl/bram_be_sp.sv
// rtl/bram_be_sp.sv - single-port block RAM with byte-lane write enables
// Purpose: synchronous RAM, 1-cycle read latency, read-first during writes.
// Ports: clk; en (access enable); we[3:0] (per-lane write enable);
//        addr (word index); wr_data; rd_data (registered read word).
module bram_be_sp
   import bus_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [BUS_SEL_W-1:0]  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [BUS_DATA_W-1:0] wr_data,
   output logic [BUS_DATA_W-1:0] rd_data
);

   logic [BUS_DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // No reset on the array or output register so the tools can infer a BRAM primitive.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < BUS_SEL_W; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
         rd_data <= mem[addr];
      end
   end

endmodule

// File: rtl/bus_slave_bram.sv
// rtl/bus_slave_bram.sv - CPU bus responder serving accesses from block RAM
// Purpose: accepts cs&as transactions, optional wait states, one-cycle ready pulse.
// Ports: clk, rst (sync, active-high); s_cs, s_as, s_addr (byte address),
//        s_wr_data, s_we, s_sel (byte lanes); s_rd_data (valid with s_ready), s_ready.
module bus_slave_bram
   import bus_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_cs,
   input  logic                  s_as,
   input  logic [BUS_ADDR_W-1:0] s_addr,
   input  logic [BUS_DATA_W-1:0] s_wr_data,
   input  logic                  s_we,
   input  logic [BUS_SEL_W-1:0]  s_sel,
   output logic [BUS_DATA_W-1:0] s_rd_data,
   output logic                  s_ready
);

   bus_state_t            state_q, state_d;
   logic [3:0]            cnt_q;
   logic [ADDR_W-1:0]     addr_q;
   logic                  we_q;
   logic [BUS_SEL_W-1:0]  sel_q;
   logic [BUS_DATA_W-1:0] wd_q;

   logic                  load, dec, commit;
   logic                  ram_en;
   logic [BUS_SEL_W-1:0]  ram_we;
   logic [BUS_DATA_W-1:0] ram_rd;

   // Byte-offset bits and bits above the RAM index are deliberately dropped (round down, alias).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_addr[BUS_ADDR_W-1:ADDR_W+2], s_addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      dec     = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_cs && s_as) begin
               load    = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Losing the grant abandons the access even on the commit cycle.
            if (!s_cs) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               dec = 1'b1;
            end else begin
               commit  = 1'b1;
               state_d = READY;
            end
         end
         READY:   state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= 4'd0;
         addr_q <= '0;
         we_q   <= 1'b0;
         sel_q  <= '0;
         wd_q   <= '0;
      end else if (load) begin
         cnt_q  <= 4'(WAIT_CYCLES);
         addr_q <= s_addr[ADDR_W+1:2];
         we_q   <= s_we;
         sel_q  <= s_sel;
         wd_q   <= s_wr_data;
      end else if (dec) begin
         cnt_q  <= cnt_q - 4'd1;
      end
   end

   // Reset on the commit edge must still block the RAM write.
   assign ram_en = (commit && !rst) ? EN : DIS_EN;
   assign ram_we = (ram_en && we_q) ? sel_q : '0;

   bram_be_sp #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .en      (ram_en),
      .we      (ram_we),
      .addr    (addr_q),
      .wr_data (wd_q),
      .rd_data (ram_rd)
   );

   assign s_ready   = (state_q == READY);
   assign s_rd_data = (state_q == READY && !we_q) ? ram_rd : '0;

endmodule

// File: tb/tb_bus_slave_bram.sv
// tb/tb_bus_slave_bram.sv - self-checking bench for bus_slave_bram
module tb_bus_slave_bram;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, as_s, we, use3;
   logic [31:0] addr, wd;
   logic [3:0]  sel;
   logic        cs0, cs3, r0, r3, ready;
   logic [31:0] d0, d3, rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign cs0   = cs & ~use3;
   assign cs3   = cs & use3;
   assign ready = use3 ? r3 : r0;
   assign rdata = use3 ? d3 : d0;

   bus_slave_bram #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .s_cs(cs0), .s_as(as_s), .s_addr(addr), .s_wr_data(wd),
      .s_we(we), .s_sel(sel), .s_rd_data(d0), .s_ready(r0));

   bus_slave_bram #(.ADDR_W(6), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .s_cs(cs3), .s_as(as_s), .s_addr(addr), .s_wr_data(wd),
      .s_we(we), .s_sel(sel), .s_rd_data(d3), .s_ready(r3));

   logic [31:0] model [0:1023];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One access: cs/as held until ready, inputs scrambled after acceptance.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat, output logic [31:0] rd);
      lat = 0;
      rd  = 32'h0;
      @(negedge clk);
      cs = 1'b1; as_s = 1'b1; we = w; addr = a; wd = d; sel = s;
      @(posedge clk);
      #1;
      addr = $urandom; wd = $urandom; we = 1'($urandom); sel = 4'($urandom);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ready) begin
            lat = k;
            rd  = rdata;
            break;
         end
         chk("rd_data_idle", rdata, 32'h0);
      end
      cs = 1'b0; as_s = 1'b0;
      if (lat == 0) chk("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("ready_one_cycle", {31'h0, ready}, 32'h0);
      chk("rd_data_after", rdata, 32'h0);
      @(negedge clk);
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin : wdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int          lat, seen, pos1, pos2, idx;
      logic [31:0] rd, rnd;
      logic        w;
      logic [3:0]  s;

      rst = 1'b1; cs = 0; as_s = 0; we = 0; addr = 0; wd = 0; sel = 0; use3 = 0;
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;

      tbl[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0};
      tbl[1] = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0};
      tbl[3] = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0};
      tbl[4] = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD};
      tbl[5] = '{1'b0, 32'h13,       32'h0,        4'h3, 32'hDEADBEEF};
      tbl[6] = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0};
      tbl[7] = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF};
      tbl[8] = '{1'b1, 32'h30,       32'hCAFEF00D, 4'hF, 32'h0};
      tbl[9] = '{1'b0, 32'hFFFFF030, 32'h0,        4'hF, 32'hCAFEF00D};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_ready0", {31'h0, r0}, 32'h0);
      chk("rst_rdata0", d0, 32'h0);
      chk("rst_ready3", {31'h0, r3}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ready0", {31'h0, r0}, 32'h0);

      // Address strobe low: no access.
      cs = 1'b1; as_s = 1'b0; we = 1'b1; addr = 32'h10; sel = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("no_as_ready", {31'h0, r0}, 32'h0);
      end
      cs = 1'b0;
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, lat, rd);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
         if (tbl[i].w) model[tbl[i].a[11:2]] = merge(model[tbl[i].a[11:2]], tbl[i].d, tbl[i].s);
      end

      // Abort: drop cs while in ACCESS.
      @(negedge clk);
      cs = 1'b1; as_s = 1'b1; we = 1'b1; addr = 32'h30; wd = 32'h5; sel = 4'hF;
      @(posedge clk);
      #1 cs = 1'b0; as_s = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("abort_no_ready", {31'h0, r0}, 32'h0);
      end

      // Reset before commit.
      cs = 1'b1; as_s = 1'b1; we = 1'b1; addr = 32'h30; wd = 32'h5; sel = 4'hF;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; cs = 1'b0; as_s = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("reset_no_ready", {31'h0, r0}, 32'h0);
      end
      access(1'b0, 32'h30, 32'h0, 4'hF, lat, rd);
      chk("abort_word_intact", rd, 32'hCAFEF00D);
      access(1'b0, 32'h30 + 32'd4096, 32'h0, 4'hF, lat, rd);
      chk("alias_read", rd, 32'hCAFEF00D);

      // Back-to-back writes with cs held high.
      @(negedge clk);
      cs = 1'b1; as_s = 1'b1; we = 1'b1; addr = 32'h50; wd = 32'h01020304; sel = 4'hF;
      @(posedge clk);
      #1;
      seen = 0; pos1 = 0; pos2 = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (r0) begin
            seen++;
            if (seen == 1) begin
               pos1 = k; addr = 32'h54; wd = 32'h0A0B0C0D;
            end else if (seen == 2) begin
               pos2 = k; cs = 1'b0; as_s = 1'b0;
            end
         end
      end
      chk("b2b_count", 32'(seen), 32'd2);
      chk("b2b_first", 32'(pos1), 32'd2);
      chk("b2b_second", 32'(pos2), 32'd6);
      access(1'b0, 32'h50, 32'h0, 4'hF, lat, rd);
      chk("b2b_word0", rd, 32'h01020304);
      access(1'b0, 32'h54, 32'h0, 4'hF, lat, rd);
      chk("b2b_word1", rd, 32'h0A0B0C0D);

      // Wait states on the WAIT_CYCLES=3 instance.
      use3 = 1'b1;
      access(1'b1, 32'h4, 32'h13572468, 4'hF, lat, rd);
      chk("ws_write_latency", 32'(lat), 32'd5);
      chk("ws_write_rdata", rd, 32'h0);
      access(1'b0, 32'h4, 32'h0, 4'h1, lat, rd);
      chk("ws_read_latency", 32'(lat), 32'd5);
      chk("ws_read_rdata", rd, 32'h13572468);
      use3 = 1'b0;

      // Randomized traffic against the reference memory.
      for (int i = 0; i < 16; i++) begin
         rnd = $urandom;
         access(1'b1, 32'h100 + 32'(4*i), rnd, 4'hF, lat, rd);
         model[10'h40 + 10'(i)] = rnd;
      end
      for (int n = 0; n < 150; n++) begin
         w   = 1'($urandom_range(0, 1));
         idx = 32'h40 + int'($urandom_range(0, 15));
         rnd = $urandom;
         s   = 4'($urandom_range(0, 15));
         addr = ($urandom & 32'hFFFFF003) | (32'(idx) << 2);
         wd  = $urandom;
         access(w, addr, rnd, s, lat, rd);
         chk("rnd_latency", 32'(lat), 32'd2);
         if (w) begin
            chk("rnd_write_rdata", rd, 32'h0);
            model[idx] = merge(model[idx], rnd, s);
         end else begin
            chk("rnd_read_rdata", rd, model[idx]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
